// File: rtl/ram_stream_reader_if.sv
//==============================================================================
// Module      : ram_stream_reader_if
// Description : Bundles the control, RAM read-port and output-stream signals of
//               ram_stream_reader.
//               master modport : the reader (drives ram_addr, out_*, busy, done)
//               slave modport  : the surroundings (drive start, base_addr,
//                                length, ram_rdata, out_ready)
//               Signals:
//                 start      1-cycle burst request
//                 base_addr  first RAM address of the burst
//                 length     number of words in the burst
//                 ram_addr   RAM read-port address
//                 ram_rdata  RAM read data (combinational from ram_addr)
//                 out_data   stream byte
//                 out_valid  stream byte valid
//                 out_ready  downstream ready
//                 busy       burst in progress
//                 done       1-cycle end-of-burst pulse
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ram_stream_reader_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, length, ram_rdata, out_ready,
        output ram_addr, out_data, out_valid, busy, done
    );

    modport slave (
        output start, base_addr, length, ram_rdata, out_ready,
        input  ram_addr, out_data, out_valid, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/ram_stream_reader.sv
//==============================================================================
// Module      : ram_stream_reader
// Description : Read-side initiator for a DEPTH-word, 8-bit RAM. A start pulse
//               in IDLE launches a burst of `length` reads from `base_addr`,
//               wrapping modulo DEPTH; each byte is presented on a valid/ready
//               stream. Two cycles per byte with the sink always ready.
//               Optional feature (macro CHECKSUM_EN): after the data bytes,
//               one extra byte equal to the two's complement of the 8-bit
//               sum of the data bytes is sent. Zero-length bursts send nothing.
// Ports       : clock  - system clock, rising edge
//               reset  - synchronous, active-high
//               sif    - ram_stream_reader_if.master (control, RAM port,
//                        output stream, status)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ram_stream_reader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 9
) (
    input  wire                 clock,
    input  wire                 reset,
    ram_stream_reader_if.master sif
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_SEND  = 3'd2;
`ifdef CHECKSUM_EN
    localparam logic [2:0] c_TAIL  = 3'd3;
`endif
    localparam logic [2:0] c_DONE  = 3'd4;

    // DEPTH is a power of two, so wrapping is a mask.
    localparam logic [ADDR_W-1:0] c_ADDR_MASK = ADDR_W'(DEPTH - 1);

    logic [2:0]        r_state_q,     w_state_d;
    logic [ADDR_W-1:0] r_ram_addr_q,  w_ram_addr_d;
    logic [LEN_W-1:0]  r_remaining_q, w_remaining_d;
    logic [7:0]        r_out_data_q,  w_out_data_d;
    logic              r_out_valid_q, w_out_valid_d;
    logic              r_busy_q,      w_busy_d;
    logic              r_done_q,      w_done_d;
`ifdef CHECKSUM_EN
    logic [7:0]        r_sum_q,       w_sum_d;
    logic [7:0]        w_sum_next;
`endif

    logic w_handshake;
    logic w_last;

    assign w_handshake = r_out_valid_q && sif.out_ready;
    assign w_last      = (r_remaining_q == LEN_W'(1));
`ifdef CHECKSUM_EN
    assign w_sum_next  = r_sum_q + r_out_data_q;
`endif

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q     <= c_IDLE;
            r_ram_addr_q  <= '0;
            r_remaining_q <= '0;
            r_out_data_q  <= '0;
            r_out_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
`ifdef CHECKSUM_EN
            r_sum_q       <= '0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_ram_addr_q  <= w_ram_addr_d;
            r_remaining_q <= w_remaining_d;
            r_out_data_q  <= w_out_data_d;
            r_out_valid_q <= w_out_valid_d;
            r_busy_q      <= w_busy_d;
            r_done_q      <= w_done_d;
`ifdef CHECKSUM_EN
            r_sum_q       <= w_sum_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE: begin
                if (sif.start) begin
                    w_state_d = (sif.length == '0) ? c_DONE : c_FETCH;
                end
            end
            c_FETCH: w_state_d = c_SEND;
            c_SEND: begin
                if (w_handshake) begin
`ifdef CHECKSUM_EN
                    w_state_d = w_last ? c_TAIL : c_FETCH;
`else
                    w_state_d = w_last ? c_DONE : c_FETCH;
`endif
                end
            end
`ifdef CHECKSUM_EN
            c_TAIL: begin
                if (w_handshake) begin
                    w_state_d = c_DONE;
                end
            end
`endif
            c_DONE:  w_state_d = c_IDLE;
            default: w_state_d = c_IDLE;
        endcase
    end

    // Output / datapath next values. done and busy are registered, so they
    // are set on the transition into DONE and cleared on the way out.
    always_comb begin
        w_ram_addr_d  = r_ram_addr_q;
        w_remaining_d = r_remaining_q;
        w_out_data_d  = r_out_data_q;
        w_out_valid_d = r_out_valid_q;
        w_busy_d      = r_busy_q;
        w_done_d      = 1'b0;
`ifdef CHECKSUM_EN
        w_sum_d       = r_sum_q;
`endif
        case (r_state_q)
            c_IDLE: begin
                if (sif.start) begin
                    w_ram_addr_d  = sif.base_addr & c_ADDR_MASK;
                    w_remaining_d = sif.length;
                    w_busy_d      = 1'b1;
                    w_done_d      = (sif.length == '0);
`ifdef CHECKSUM_EN
                    w_sum_d       = '0;
`endif
                end
            end
            c_FETCH: begin
                w_out_data_d  = sif.ram_rdata;
                w_out_valid_d = 1'b1;
            end
            c_SEND: begin
                if (w_handshake) begin
                    w_out_valid_d = 1'b0;
                    w_remaining_d = r_remaining_q - LEN_W'(1);
`ifdef CHECKSUM_EN
                    w_sum_d       = w_sum_next;
`endif
                    if (w_last) begin
`ifdef CHECKSUM_EN
                        // Checksum byte follows immediately; the sum must
                        // include the byte completing in this cycle.
                        w_out_data_d  = 8'd0 - w_sum_next;
                        w_out_valid_d = 1'b1;
`else
                        w_done_d      = 1'b1;
`endif
                    end else begin
                        w_ram_addr_d = (r_ram_addr_q + ADDR_W'(1)) & c_ADDR_MASK;
                    end
                end
            end
`ifdef CHECKSUM_EN
            c_TAIL: begin
                if (w_handshake) begin
                    w_out_valid_d = 1'b0;
                    w_done_d      = 1'b1;
                end
            end
`endif
            c_DONE: w_busy_d = 1'b0;
            default: begin
                w_out_valid_d = 1'b0;
                w_busy_d      = 1'b0;
            end
        endcase
    end

    assign sif.ram_addr  = r_ram_addr_q;
    assign sif.out_data  = r_out_data_q;
    assign sif.out_valid = r_out_valid_q;
    assign sif.busy      = r_busy_q;
    assign sif.done      = r_done_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
//==============================================================================
// Module      : tb_ram_stream_reader
// Description : Directed self-checking bench for ram_stream_reader with a
//               16x8 RAM model preloaded with mem[i] = 8'h10 + i.
//               Honours the CHECKSUM_EN macro in the same way as the design.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ram_stream_reader;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] mem [16];

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q [$];

    always #5 clock = ~clock;

    ram_stream_reader_if #(.ADDR_W(8), .LEN_W(9)) sif ();

    assign sif.ram_rdata = mem[sif.ram_addr[3:0]];

    ram_stream_reader #(
        .ADDR_W (8),
        .DEPTH  (16),
        .LEN_W  (9)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sif   (sif)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one burst using the bytes in exp_q. The first byte is held off
    // by `stall` cycles of out_ready low. cks is the expected checksum byte.
    task automatic burst(input string tag, input logic [7:0] base, input logic [8:0] len,
                         input int stall, input logic [7:0] cks);
        sif.start     = 1'b1;
        sif.base_addr = base;
        sif.length    = len;
        tick();
        sif.start = 1'b0;
        chk({tag, "_busy_start"}, 32'(sif.busy), 32'd1);
        chk({tag, "_valid_lat1"}, 32'(sif.out_valid), 32'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 0 && stall > 0) sif.out_ready = 1'b0;
            tick();
            chk($sformatf("%s_valid%0d", tag, i), 32'(sif.out_valid), 32'd1);
            chk($sformatf("%s_data%0d", tag, i), 32'(sif.out_data), 32'(exp_q[i]));
            chk($sformatf("%s_addr%0d", tag, i), 32'(sif.ram_addr), 32'(exp_q[i] - 8'h10));
            if (i == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    tick();
                    chk($sformatf("%s_hold_valid%0d", tag, s), 32'(sif.out_valid), 32'd1);
                    chk($sformatf("%s_hold_data%0d", tag, s), 32'(sif.out_data), 32'(exp_q[0]));
                end
                sif.out_ready = 1'b1;
            end
            tick();
            if (i != exp_q.size() - 1) begin
                chk($sformatf("%s_gap%0d", tag, i), 32'(sif.out_valid), 32'd0);
            end
        end
`ifdef CHECKSUM_EN
        chk({tag, "_cks_valid"}, 32'(sif.out_valid), 32'd1);
        chk({tag, "_cks_data"}, 32'(sif.out_data), 32'(cks));
        tick();
`else
        if (cks == 8'h00) $display("note: zero checksum byte for %s", tag);
`endif
        chk({tag, "_end_valid"}, 32'(sif.out_valid), 32'd0);
        chk({tag, "_done"}, 32'(sif.done), 32'd1);
        chk({tag, "_busy_done"}, 32'(sif.busy), 32'd1);
        tick();
        chk({tag, "_done_clr"}, 32'(sif.done), 32'd0);
        chk({tag, "_busy_clr"}, 32'(sif.busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        sif.start     = 1'b0;
        sif.base_addr = '0;
        sif.length    = '0;
        sif.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_addr",  32'(sif.ram_addr),  32'd0);
        chk("rst_data",  32'(sif.out_data),  32'd0);
        chk("rst_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_busy",  32'(sif.busy),      32'd0);
        chk("rst_done",  32'(sif.done),      32'd0);

        // Straight burst
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        burst("b0l4", 8'd0, 9'd4, 0, 8'hBA);

        // Wrap past DEPTH-1
        exp_q = '{8'h1E, 8'h1F, 8'h10, 8'h11};
        burst("b14l4", 8'd14, 9'd4, 0, 8'hA2);

        // Base address above DEPTH is masked
        exp_q = '{8'h15};
        burst("b37l1", 8'd37, 9'd1, 0, 8'hEB);

        // Backpressure on the first byte
        exp_q = '{8'h13, 8'h14};
        burst("stall", 8'd3, 9'd2, 5, 8'hD9);

        // Checksum reference case (plain bytes without the macro)
        exp_q = '{8'h10, 8'h11};
        burst("b0l2", 8'd0, 9'd2, 0, 8'hDF);

        // Zero-length burst: single cycle of busy with done, nothing sent
        sif.start     = 1'b1;
        sif.base_addr = 8'd5;
        sif.length    = 9'd0;
        tick();
        sif.start = 1'b0;
        chk("len0_done",  32'(sif.done),      32'd1);
        chk("len0_busy",  32'(sif.busy),      32'd1);
        chk("len0_valid", 32'(sif.out_valid), 32'd0);
        tick();
        chk("len0_done_clr", 32'(sif.done),      32'd0);
        chk("len0_busy_clr", 32'(sif.busy),      32'd0);
        chk("len0_valid2",   32'(sif.out_valid), 32'd0);

        // Start while busy is ignored; reset mid-burst aborts cleanly
        sif.start     = 1'b1;
        sif.base_addr = 8'd0;
        sif.length    = 9'd4;
        tick();
        sif.base_addr = 8'd8;
        sif.length    = 9'd1;
        tick();
        sif.start = 1'b0;
        chk("ign_valid", 32'(sif.out_valid), 32'd1);
        chk("ign_data",  32'(sif.out_data),  32'h10);
        chk("ign_addr",  32'(sif.ram_addr),  32'd0);
        tick();
        chk("ign_busy",  32'(sif.busy),      32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_valid", 32'(sif.out_valid), 32'd0);
        chk("abort_busy",  32'(sif.busy),      32'd0);
        chk("abort_done",  32'(sif.done),      32'd0);
        chk("abort_addr",  32'(sif.ram_addr),  32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort_nodone%0d", i), 32'(sif.done), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
